// File: rtl/datapath_pkg.sv
// Shared datapath definitions: histogram FSM encoding and the bin geometry
// common to the binning stage and the histogram accumulator.
package datapath_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DUMP  = 2'd2
    } hist_state_e;

    localparam int unsigned HIST_BINS_DEFAULT        = 30;
    localparam int unsigned HIST_COUNT_WIDTH_DEFAULT = 16;
    localparam int unsigned HIST_INDEX_WIDTH         = 8;

endpackage

// File: rtl/hist_bin_counter.sv
// Single histogram bin: increment, clear and load-one, with priority load > clear > inc.
// Macro HISTOGRAM_ACCUMULATOR_SATURATE_EN selects saturation instead of wrap-around.
module hist_bin_counter #(
    parameter int unsigned p_count_width = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     inc_i,
    input  logic                     clr_i,
    input  logic                     load_one_i,
    output logic [p_count_width-1:0] count_o
);

    logic [p_count_width-1:0] count_q;
    logic [p_count_width-1:0] count_d;
    logic [p_count_width-1:0] count_inc;

`ifdef HISTOGRAM_ACCUMULATOR_SATURATE_EN
    assign count_inc = (&count_q) ? count_q : count_q + 1'b1;
`else
    assign count_inc = count_q + 1'b1;
`endif

    always_comb begin
        count_d = count_q;
        if (load_one_i) begin
            count_d = {{(p_count_width-1){1'b0}}, 1'b1};
        end else if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/histogram_accumulator.sv
// Per-frame histogram accumulator: counts bin indices, dumps the completed frame
// on the next start-of-frame. Counter overflow set by HISTOGRAM_ACCUMULATOR_SATURATE_EN.
module histogram_accumulator
    import datapath_pkg::*;
#(
    parameter int unsigned p_bins        = HIST_BINS_DEFAULT,
    parameter int unsigned p_count_width = HIST_COUNT_WIDTH_DEFAULT
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [HIST_INDEX_WIDTH-1:0] data_in,
    input  logic                        valid_in,
    input  logic                        sof_in,
    output logic                        busy_out,
    output logic [p_count_width-1:0]    data_out,
    output logic                        valid_out,
    output logic                        sof_out,
    input  logic                        busy_in
);

    localparam logic [HIST_INDEX_WIDTH-1:0] LAST_IDX = HIST_INDEX_WIDTH'(p_bins - 1);

    hist_state_e                 state_q, state_d;
    logic [HIST_INDEX_WIDTH-1:0] k_q, k_d;
    logic [HIST_INDEX_WIDTH-1:0] pend_q, pend_d;
    logic [p_count_width-1:0]    data_q, data_d;
    logic                        valid_q, valid_d;
    logic                        sof_q, sof_d;

    logic [p_count_width-1:0]    count [p_bins];
    logic [p_bins-1:0]           inc, clr, load;
    logic [p_bins-1:0]           din_hot, k_hot, pend_hot;
    logic [p_count_width-1:0]    count_first, count_next;
    logic [HIST_INDEX_WIDTH-1:0] k_next;
    logic                        accept;

    assign busy_out = (state_q == ST_DUMP);
    assign accept   = valid_in && !busy_out;
    assign k_next   = k_q + 8'd1;

    // Out-of-range indices decode to an all-zero one-hot, so they touch no bin.
    always_comb begin
        din_hot     = '0;
        k_hot       = '0;
        pend_hot    = '0;
        count_first = count[0];
        count_next  = '0;
        for (int i = 0; i < p_bins; i++) begin
            if (data_in == HIST_INDEX_WIDTH'(i)) din_hot[i]  = 1'b1;
            if (k_q     == HIST_INDEX_WIDTH'(i)) k_hot[i]    = 1'b1;
            if (pend_q  == HIST_INDEX_WIDTH'(i)) pend_hot[i] = 1'b1;
            if (k_next  == HIST_INDEX_WIDTH'(i)) count_next  = count[i];
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        pend_d  = pend_q;
        data_d  = data_q;
        valid_d = valid_q;
        sof_d   = sof_q;
        inc     = '0;
        clr     = '0;
        load    = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept && sof_in) begin
                    inc     = din_hot;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept && sof_in) begin
                    pend_d  = data_in;
                    k_d     = '0;
                    data_d  = count_first;
                    valid_d = 1'b1;
                    sof_d   = 1'b1;
                    state_d = ST_DUMP;
                end else if (accept) begin
                    inc = din_hot;
                end
            end
            ST_DUMP: begin
                if (!busy_in) begin
                    clr   = k_hot;
                    sof_d = 1'b0;
                    if (k_q == LAST_IDX) begin
                        load    = pend_hot;
                        k_d     = '0;
                        data_d  = '0;
                        valid_d = 1'b0;
                        state_d = ST_ACCUM;
                    end else begin
                        k_d    = k_next;
                        data_d = count_next;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            pend_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
        end
    end

    for (genvar g = 0; g < p_bins; g++) begin : g_bin
        hist_bin_counter #(
            .p_count_width (p_count_width)
        ) u_bin (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .inc_i      (inc[g]),
            .clr_i      (clr[g]),
            .load_one_i (load[g]),
            .count_o    (count[g])
        );
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign sof_out   = sof_q;

endmodule

// File: tb/tb_histogram_accumulator.sv
// Self-checking bench for histogram_accumulator: directed frames plus random frames
// checked against a frame-level histogram model (4-bit counters to exercise overflow).
module tb_histogram_accumulator;

    localparam int BINS = 30;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    data_in;
    logic          valid_in;
    logic          sof_in;
    logic          busy_out;
    logic [CW-1:0] data_out;
    logic          valid_out;
    logic          sof_out;
    logic          busy_in;

    int n_cmp = 0;
    int n_err = 0;

    int  cnt [BINS];
    int  expv [BINS];
    bit  started;

    always #5 clk = ~clk;

    histogram_accumulator #(
        .p_bins        (BINS),
        .p_count_width (CW)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .sof_in    (sof_in),
        .busy_out  (busy_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .sof_out   (sof_out),
        .busy_in   (busy_in)
    );

    function automatic int bump(input int v);
`ifdef HISTOGRAM_ACCUMULATOR_SATURATE_EN
        return (v >= MAXC) ? MAXC : v + 1;
`else
        return (v + 1) % (MAXC + 1);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < BINS; i++) cnt[i] = 0;
    endtask

    // Non-frame-boundary sample; sof only used to open a frame from IDLE.
    task automatic send(input int idx, input bit sof);
        valid_in = 1'b1;
        data_in  = 8'(idx);
        sof_in   = sof;
        tick();
        valid_in = 1'b0;
        sof_in   = 1'b0;
        if (!started) begin
            if (sof) begin
                started = 1'b1;
                if (idx < BINS) cnt[idx] = bump(cnt[idx]);
            end
        end else if (idx < BINS) begin
            cnt[idx] = bump(cnt[idx]);
        end
    endtask

    task automatic sof_dump(input int idx, input int stall_k, input int stall_n,
                            input bit hold, input int hold_idx);
        valid_in = 1'b1;
        data_in  = 8'(idx);
        sof_in   = 1'b1;
        tick();
        for (int i = 0; i < BINS; i++) expv[i] = cnt[i];
        model_clear();
        if (idx < BINS) cnt[idx] = 1;
        sof_in = 1'b0;
        if (hold) data_in = 8'(hold_idx);
        else      valid_in = 1'b0;
        for (int k = 0; k < BINS; k++) begin
            if (k == stall_k) begin
                busy_in = 1'b1;
                for (int s = 0; s < stall_n; s++) begin
                    chk("stall_valid", 32'(valid_out), 32'd1);
                    chk("stall_data", 32'(data_out), 32'(expv[k]));
                    chk("stall_busy", 32'(busy_out), 32'd1);
                    tick();
                end
                busy_in = 1'b0;
            end
            chk($sformatf("dump_valid[%0d]", k), 32'(valid_out), 32'd1);
            chk($sformatf("dump_data[%0d]", k), 32'(data_out), 32'(expv[k]));
            chk($sformatf("dump_sof[%0d]", k), 32'(sof_out), (k == 0) ? 32'd1 : 32'd0);
            chk($sformatf("dump_busy[%0d]", k), 32'(busy_out), 32'd1);
            tick();
        end
        chk("post_busy", 32'(busy_out), 32'd0);
        chk("post_valid", 32'(valid_out), 32'd0);
        chk("post_data", 32'(data_out), 32'd0);
        chk("post_sof", 32'(sof_out), 32'd0);
        if (hold) begin
            tick();
            valid_in = 1'b0;
            if (hold_idx < BINS) cnt[hold_idx] = bump(cnt[hold_idx]);
        end
    endtask

    initial begin
        rst      = 1'b1;
        data_in  = '0;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        busy_in  = 1'b0;
        started  = 1'b0;
        model_clear();
        tick();
        tick();
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_sof", 32'(sof_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        rst = 1'b0;
        tick();

        // IDLE discards, then frame 3,3,3,7 with out-of-range noise; stall at k=4
        send(5, 0);
        send(29, 0);
        send(40, 0);
        send(3, 1);
        send(3, 0);
        send(3, 0);
        send(30, 0);
        send(255, 0);
        send(7, 0);
        sof_dump(0, 4, 5, 0, 0);

        // 17 hits on bin 2 overflow a 4-bit counter; pending index out of range
        for (int i = 0; i < 17; i++) send(2, 0);
        sof_dump(40, -1, 0, 0, 0);

        // valid_in held through the dump: only the beat at busy_out fall counts
        send(12, 0);
        sof_dump(9, -1, 0, 1, 11);
        send(11, 0);
        sof_dump(1, 29, 2, 0, 0);

        // Reset while bin 10 is on the output
        send(4, 0);
        send(10, 0);
        valid_in = 1'b1;
        data_in  = 8'd6;
        sof_in   = 1'b1;
        tick();
        valid_in = 1'b0;
        sof_in   = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("pre_rst_valid", 32'(valid_out), 32'd1);
        chk("pre_rst_data", 32'(data_out), 32'(cnt[10]));
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(valid_out), 32'd0);
        chk("mid_rst_busy", 32'(busy_out), 32'd0);
        rst = 1'b0;
        started = 1'b0;
        model_clear();
        tick();
        chk("after_rst_valid", 32'(valid_out), 32'd0);
        send(8, 0);
        send(13, 1);
        send(13, 0);
        send(21, 0);
        sof_dump(2, -1, 0, 0, 0);

        // Random frames
        for (int f = 0; f < 12; f++) begin
            int n;
            n = int'($urandom_range(10, 50));
            for (int s = 0; s < n; s++) begin
                send(int'($urandom_range(0, 35)), 0);
                if ($urandom_range(0, 3) == 0) tick();
            end
            sof_dump(int'($urandom_range(0, 33)), int'($urandom_range(0, 40)),
                     int'($urandom_range(1, 4)), bit'($urandom_range(0, 1)),
                     int'($urandom_range(0, 31)));
        end
        sof_dump(0, -1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/histogram_accumulator.md
HISTOGRAM_ACCUMULATOR -- requirements
Module: histogram_accumulator

Interface
REQ-001 Parameter p_bins, default 30, number of histogram bins; legal range 1..256.
REQ-002 Parameter p_count_width, default 16, width of each bin counter and of data_out.
REQ-003 i_clk  input  1  clock; all state changes on the rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 data_in  input  8  bin index from the upstream histogram binning stage.
REQ-006 valid_in  input  1  data_in valid; a sample is accepted in a cycle with valid_in=1 and busy_out=0.
REQ-007 sof_in  input  1  start of frame, qualified by valid_in; the marked sample belongs to the new frame.
REQ-008 busy_out  output  1  back-pressure to upstream; high while bins are being dumped.
REQ-009 data_out  output  p_count_width  bin count of the completed frame.
REQ-010 valid_out  output  1  data_out valid.
REQ-011 sof_out  output  1  high with bin 0 of each dumped histogram.
REQ-012 busy_in  input  1  downstream stall; an output transfer occurs in a cycle with valid_out=1 and busy_in=0.

Function
REQ-013 The block SHALL use a three-state FSM: IDLE (no frame started), ACCUM (counting), DUMP (emitting the previous frame).
REQ-014 IDLE: accepted samples without sof_in SHALL be discarded; an accepted sample with sof_in SHALL be counted, with transition to ACCUM.
REQ-015 ACCUM: an accepted sample without sof_in SHALL increment count[data_in] by 1 on the next edge.
REQ-016 A sample with data_in >= p_bins SHALL be dropped and SHALL change no counter.
REQ-017 Back-to-back samples to the same bin SHALL each be counted; there is no read-modify-write hazard, because counters are registers.
REQ-018 ACCUM: an accepted sample with sof_in at cycle T SHALL be stored as pending, and the FSM SHALL enter DUMP at T+1.
REQ-019 busy_out SHALL equal (state == DUMP), decoded combinationally from the state register.
REQ-020 DUMP: valid_out=1 and data_out=count[k] SHALL hold for k = 0..p_bins-1, with sof_out=1 only for k=0.
REQ-021 k SHALL advance only on a transfer; while busy_in=1, data_out, sof_out and valid_out SHALL stay stable.
REQ-022 count[k] SHALL be cleared on the edge on which bin k transfers.
REQ-023 On transfer of bin p_bins-1, the FSM SHALL return to ACCUM and the pending sample SHALL be counted, giving count[pending]=1 if the pending index is in range.
REQ-024 With busy_in=0 throughout, sof accepted at T SHALL give bins at T+1..T+p_bins, with busy_out low again at T+p_bins+1.
REQ-025 Outside DUMP, valid_out and sof_out SHALL be 0, and data_out SHALL be 0.
REQ-026 Counter overflow SHALL follow the configuration macro (REQ-030).

Reset
REQ-027 While i_rst=1, the block SHALL clear all counters and the pending sample, and set the state to IDLE.
REQ-028 Reset values: busy_out=0, valid_out=0, sof_out=0, data_out=0.
REQ-029 Reset during DUMP SHALL abort the dump immediately, with no further output beats and no partial frame resumed.

Configuration
REQ-030 Macro HISTOGRAM_ACCUMULATOR_SATURATE_EN: defined -> counters saturate at 2^p_count_width-1; undefined -> counters wrap modulo 2^p_count_width.

Structure
REQ-031 The shared package datapath_pkg SHALL hold the FSM state encoding (IDLE, ACCUM, DUMP) and the default bin-count and count-width constants shared with the binning stage.
REQ-032 Each bin SHALL be an instance of the sub-module hist_bin_counter, providing increment, clear, load-one and the optional saturation.
REQ-033 The top level SHALL hold the FSM, the dump index, the pending register and the output registers.

Verification
REQ-034 Frame counting: sof+bin 3, then bins 3,3,7, then sof+bin 0 -> dump shows bin3=3, bin7=1, all others 0, sof_out only with bin 0; after the dump, count[0]=1.
REQ-035 Dump stall: busy_in=1 for 5 cycles at k=4 -> data_out and valid_out stable; exactly p_bins transfers; busy_out high until the last transfer.
REQ-036 Out of range and IDLE: data_in=30 and 255 with p_bins=30 -> all counters unchanged; samples in IDLE without sof -> no count.
REQ-037 Overflow: p_count_width=4, 17 hits on bin 2 -> dump value 15 with the macro defined, 1 without.
REQ-038 Reset mid-dump: i_rst at k=10 -> valid_out=0 next cycle; state IDLE; a new sof frame dumps all-zero except its own samples.
REQ-039 Back-pressure: valid_in held high while busy_out=1 -> no sample accepted; a sample presented at the cycle busy_out falls is counted once.
